// File: rtl/window_filter_3x3_if.sv
// Row-stream input and filtered-pixel output bundle for window_filter_3x3.
// The master drives the three row pixels; the slave returns one filtered pixel per window.
interface window_filter_3x3_if #(
    parameter int DW = 8,
    parameter int CH = 3,
    parameter int CW = 10
);
    logic               valid_in;
    logic               sol;
    logic [1:0]         mode;
    logic [CH*DW-1:0]   din1;
    logic [CH*DW-1:0]   din2;
    logic [CH*DW-1:0]   din3;
    logic               valid_out;
    logic [CH*DW-1:0]   dout;
    logic [CW-1:0]      col_out;

    modport master (
        output valid_in, sol, mode, din1, din2, din3,
        input  valid_out, dout, col_out
    );

    modport slave (
        input  valid_in, sol, mode, din1, din2, din3,
        output valid_out, dout, col_out
    );
endinterface

// File: rtl/window_filter_3x3.sv
// 3x3 per-channel mean/min/max/centre filter over three aligned row streams.
// Latency: valid_out 2 clk after the edge accepting the window-completing pixel.
// No backpressure: stall-free, one result per accepted column once a window is full.
module window_filter_3x3 #(
    parameter int DW        = 8,
    parameter int CH        = 3,
    parameter int PIC_WIDTH = 640,
    parameter int CW        = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    window_filter_3x3_if.slave bus
);
    localparam int PW = CH * DW;
    localparam int SW = DW + 4;

    // w[row][age]: age 0 is the newest column, age 2 the oldest
    logic [PW-1:0] w [3][3];
    logic [CW-1:0] col;
    logic [1:0]    mode_q;
    logic          first_q;
    logic          win_vld;
    logic [CW-1:0] win_col;
    logic          complete;

    logic          s1_vld;
    logic [CW-1:0] s1_col;
    logic [1:0]    s1_mode;
    logic [SW-1:0] s1_sum [CH];
    logic [DW-1:0] s1_min [CH];
    logic [DW-1:0] s1_max [CH];
    logic [PW-1:0] s1_ctr;

    logic [SW-1:0] sum_c  [CH];
    logic [DW-1:0] min_c  [CH];
    logic [DW-1:0] max_c  [CH];
    logic [DW-1:0] smp;
    logic [SW-1:0] quot;
    logic [PW-1:0] dout_nxt;

    // Columns 0 and 1 of a line never complete a window, so no window straddles a line start.
    assign complete = bus.valid_in && !bus.sol && (col >= CW'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w[r][c] <= '0;
            col     <= '0;
            mode_q  <= '0;
            first_q <= 1'b1;
            win_vld <= 1'b0;
            win_col <= '0;
        end else begin
            win_vld <= complete;
            if (bus.valid_in) begin
                w[0][0] <= bus.din1;
                w[1][0] <= bus.din2;
                w[2][0] <= bus.din3;
                for (int r = 0; r < 3; r++) begin
                    w[r][1] <= w[r][0];
                    w[r][2] <= w[r][1];
                end
                win_col <= col;
                if (bus.sol)
                    col <= CW'(1);
                else if (col == CW'(PIC_WIDTH - 1))
                    col <= '0;
                else
                    col <= col + CW'(1);
                if (bus.sol || first_q) begin
                    mode_q  <= bus.mode;
                    first_q <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        smp = '0;
        for (int ch = 0; ch < CH; ch++) begin
            sum_c[ch] = '0;
            min_c[ch] = '1;
            max_c[ch] = '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    smp       = w[r][c][ch*DW +: DW];
                    sum_c[ch] = sum_c[ch] + SW'(smp);
                    if (smp < min_c[ch]) min_c[ch] = smp;
                    if (smp > max_c[ch]) max_c[ch] = smp;
                end
            end
        end
    end

    // mode_q cannot change before this stage samples it, since a completing pixel is never an sol
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_col  <= '0;
            s1_mode <= '0;
            s1_ctr  <= '0;
            for (int ch = 0; ch < CH; ch++) begin
                s1_sum[ch] <= '0;
                s1_min[ch] <= '0;
                s1_max[ch] <= '0;
            end
        end else begin
            s1_vld <= win_vld;
            if (win_vld) begin
                s1_col  <= win_col;
                s1_mode <= mode_q;
                s1_ctr  <= w[1][1];
                for (int ch = 0; ch < CH; ch++) begin
                    s1_sum[ch] <= sum_c[ch];
                    s1_min[ch] <= min_c[ch];
                    s1_max[ch] <= max_c[ch];
                end
            end
        end
    end

    always_comb begin
        dout_nxt = '0;
        quot     = '0;
        for (int ch = 0; ch < CH; ch++) begin
            quot = s1_sum[ch] / SW'(9);
            case (s1_mode)
                2'd0:    dout_nxt[ch*DW +: DW] = quot[DW-1:0];
                2'd1:    dout_nxt[ch*DW +: DW] = s1_min[ch];
                2'd2:    dout_nxt[ch*DW +: DW] = s1_max[ch];
                default: dout_nxt[ch*DW +: DW] = s1_ctr[ch*DW +: DW];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.valid_out <= 1'b0;
            bus.dout      <= '0;
            bus.col_out   <= '0;
        end else begin
            bus.valid_out <= s1_vld;
            if (s1_vld) begin
                bus.dout    <= dout_nxt;
                bus.col_out <= s1_col - CW'(1);
            end
        end
    end
endmodule
